// File: rtl/addsub_result_bcd_pkg.sv
// Shared types and constants for the adder/subtractor result display stage.
// Holds the FSM state encoding, iteration count and 7-segment patterns.
package addsub_result_bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int unsigned N_ITER = 5;
  localparam logic [2:0] ITER_LAST = 3'(N_ITER - 1);

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/addsub_result_bcd_bcd_to_7seg.sv
// BCD digit to 7-segment decoder, gfedcba active-high.
// Non-decimal codes produce a blank pattern.
module bcd_to_7seg
  import addsub_result_bcd_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Pure lookup; codes 10-15 blank the display
  always_comb begin
    seg = SEG_BLANK;
    unique case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/addsub_result_bcd.sv
// Serial double-dabble conversion of a 5-bit signed-magnitude result
// into two BCD digits with registered 7-segment patterns.
module addsub_result_bcd
  import addsub_result_bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] in_mag,
  input  logic       in_neg,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [3:0] out_tens,
  output logic [3:0] out_ones,
  output logic       out_neg,
  output logic [6:0] seg_tens,
  output logic [6:0] seg_ones,
  output logic       out_valid,
  input  logic       out_ready
);

  state_e      state_q, state_d;
  logic [12:0] work_q, work_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        sign_q, sign_d;
  logic [3:0]  tens_q, tens_d;
  logic [3:0]  ones_q, ones_d;
  logic        neg_q, neg_d;
  logic [6:0]  segt_q, segt_d;
  logic [6:0]  sego_q, sego_d;
  logic        oval_q, oval_d;

  logic [12:0] work_adj;
  logic [12:0] work_shl;
  logic [6:0]  segt_w;
  logic [6:0]  sego_w;

  // Decoders see the nibbles the final shift will produce
  bcd_to_7seg u_seg_tens (
    .bcd (work_shl[12:9]),
    .seg (segt_w)
  );

  bcd_to_7seg u_seg_ones (
    .bcd (work_shl[8:5]),
    .seg (sego_w)
  );

  // One double-dabble step: add-3 correction then shift left
  always_comb begin
    work_adj = work_q;
    if (work_adj[8:5] >= 4'd5)
      work_adj[8:5] = work_adj[8:5] + 4'd3;
    if (work_adj[12:9] >= 4'd5)
      work_adj[12:9] = work_adj[12:9] + 4'd3;
    work_shl = work_adj << 1;
  end

  // Next-state and output-register logic
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    neg_d   = neg_q;
    segt_d  = segt_q;
    sego_d  = sego_q;
    oval_d  = oval_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_SHIFT;
          work_d  = {8'b0, in_mag};
          sign_d  = in_neg & (in_mag != 5'd0);
          cnt_d   = 3'd0;
        end
      end
      ST_SHIFT: begin
        work_d = work_shl;
        cnt_d  = cnt_q + 3'd1;
        if (cnt_q == ITER_LAST) begin
          state_d = ST_DONE;
          oval_d  = 1'b1;
          tens_d  = work_shl[12:9];
          ones_d  = work_shl[8:5];
          neg_d   = sign_q;
          segt_d  = (work_shl[12:9] == 4'd0)
                    ? SEG_BLANK : segt_w;
          sego_d  = sego_w;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
          oval_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        oval_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      tens_q  <= '0;
      ones_q  <= '0;
      neg_q   <= 1'b0;
      segt_q  <= SEG_BLANK;
      sego_q  <= SEG_BLANK;
      oval_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      neg_q   <= neg_d;
      segt_q  <= segt_d;
      sego_q  <= sego_d;
      oval_q  <= oval_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE) & ~rst;
  assign out_tens  = tens_q;
  assign out_ones  = ones_q;
  assign out_neg   = neg_q;
  assign seg_tens  = segt_q;
  assign seg_ones  = sego_q;
  assign out_valid = oval_q;

endmodule

// File: tb/tb_addsub_result_bcd.sv
// Directed bench for the BCD display stage: vector table,
// backpressure, mid-conversion reset and a full 64-value sweep.
module tb_addsub_result_bcd;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] in_mag;
  logic       in_neg;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] out_tens;
  logic [3:0] out_ones;
  logic       out_neg;
  logic [6:0] seg_tens;
  logic [6:0] seg_ones;
  logic       out_valid;
  logic       out_ready;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  addsub_result_bcd dut (
    .clk       (clk),
    .rst       (rst),
    .in_mag    (in_mag),
    .in_neg    (in_neg),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_tens  (out_tens),
    .out_ones  (out_ones),
    .out_neg   (out_neg),
    .seg_tens  (seg_tens),
    .seg_ones  (seg_ones),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  typedef struct {
    logic [4:0] mag;
    logic       neg;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       oneg;
    logic [6:0] segt;
    logic [6:0] sego;
  } vec_t;

  vec_t vecs [7];
  logic [6:0] segtab [10];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pack all outputs into one word for compact comparison
  function automatic logic [31:0] pack_out();
    return {9'd0, out_valid, out_neg, out_tens, out_ones,
            seg_tens, seg_ones};
  endfunction

  function automatic logic [31:0] model(input logic [4:0] m,
                                       input logic n);
    logic [3:0] t, o;
    logic [6:0] st, so;
    t  = 4'(m / 10);
    o  = 4'(m % 10);
    st = (t == 4'd0) ? 7'h00 : segtab[t];
    so = segtab[o];
    return {9'd0, 1'b1, n & (m != 0), t, o, st, so};
  endfunction

  // Wait (bounded) for in_ready, then hold in_valid across one edge
  task automatic accept(input logic [4:0] m, input logic n);
    int w = 0;
    in_mag = m;
    in_neg = n;
    in_valid = 1'b1;
    while (!in_ready && w < 30) begin
      step();
      w++;
    end
    if (!in_ready) chk("accept_timeout", 0, 1);
    step();
    in_valid = 1'b0;
    in_mag = 5'h1F;
    in_neg = 1'b1;
  endtask

  // Count cycles from accept edge to out_valid
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
  endtask

  initial begin
    int lat;
    int prev_acc;
    logic [31:0] snap;

    segtab[0] = 7'h3F; segtab[1] = 7'h06;
    segtab[2] = 7'h5B; segtab[3] = 7'h4F;
    segtab[4] = 7'h66; segtab[5] = 7'h6D;
    segtab[6] = 7'h7D; segtab[7] = 7'h07;
    segtab[8] = 7'h7F; segtab[9] = 7'h6F;

    vecs[0] = '{5'd30, 1'b0, 4'd3, 4'd0, 1'b0, 7'h4F, 7'h3F};
    vecs[1] = '{5'd7,  1'b1, 4'd0, 4'd7, 1'b1, 7'h00, 7'h07};
    vecs[2] = '{5'd0,  1'b1, 4'd0, 4'd0, 1'b0, 7'h00, 7'h3F};
    vecs[3] = '{5'd19, 1'b0, 4'd1, 4'd9, 1'b0, 7'h06, 7'h6F};
    vecs[4] = '{5'd31, 1'b1, 4'd3, 4'd1, 1'b1, 7'h4F, 7'h06};
    vecs[5] = '{5'd10, 1'b0, 4'd1, 4'd0, 1'b0, 7'h06, 7'h3F};
    vecs[6] = '{5'd25, 1'b1, 4'd2, 4'd5, 1'b1, 7'h5B, 7'h6D};

    rst = 1'b1;
    in_mag = '0;
    in_neg = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    chk("rst_outputs", pack_out(), 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Table-driven vectors
    for (int i = 0; i < 7; i++) begin
      accept(vecs[i].mag, vecs[i].neg);
      wait_valid(lat);
      chk("vec_latency", lat, 5);
      chk("vec_tens", {28'd0, out_tens}, {28'd0, vecs[i].tens});
      chk("vec_ones", {28'd0, out_ones}, {28'd0, vecs[i].ones});
      chk("vec_neg", {31'd0, out_neg}, {31'd0, vecs[i].oneg});
      chk("vec_segt", {25'd0, seg_tens}, {25'd0, vecs[i].segt});
      chk("vec_sego", {25'd0, seg_ones}, {25'd0, vecs[i].sego});
      step();
      chk("vec_handshake", {31'd0, out_valid}, 32'd0);
    end

    // Backpressure: hold outputs for 10 cycles, ignore in_valid
    out_ready = 1'b0;
    step();
    chk("idle_ready_nop", {31'd0, out_valid}, 32'd0);
    accept(5'd23, 1'b0);
    wait_valid(lat);
    chk("bp_latency", lat, 5);
    snap = pack_out();
    chk("bp_value", snap, model(5'd23, 1'b0));
    for (int c = 0; c < 10; c++) begin
      if (c == 3) begin
        in_mag = 5'd4;
        in_neg = 1'b1;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      step();
      chk("bp_hold", pack_out(), snap);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("bp_release_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
    for (int c = 0; c < 8; c++) step();
    chk("bp_pulse_ignored", {31'd0, out_valid}, 32'd0);

    // Reset during the third SHIFT cycle
    accept(5'd28, 1'b1);
    step();
    step();
    rst = 1'b1;
    step();
    chk("midrst_outputs", pack_out(), 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("midrst_ready_after", {31'd0, in_ready}, 32'd1);
    for (int c = 0; c < 7; c++) step();
    chk("midrst_no_output", {31'd0, out_valid}, 32'd0);
    accept(5'd19, 1'b0);
    wait_valid(lat);
    chk("midrst_19_lat", lat, 5);
    chk("midrst_19", pack_out(), model(5'd19, 1'b0));
    step();

    // Back-to-back sweep of all sign/magnitude combinations
    prev_acc = 0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      int w = 0;
      in_mag = 5'(i);
      in_neg = i[5];
      while (!in_ready && w < 30) begin
        step();
        w++;
      end
      step();
      if (i > 0) chk("sweep_gap", cyc - prev_acc, 7);
      prev_acc = cyc;
      in_mag = ~5'(i);
      in_neg = ~i[5];
      wait_valid(lat);
      chk("sweep_value", pack_out(),
          model(5'(i), i[5]));
      step();
    end
    in_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
